// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared TMDS types and symbol constants for the encoder bank.
// The TERC4 table is only compiled in when HDMI_TMDS_TERC4_EN is defined.
package hdmi_pkg;

    localparam int SYM_W = 10;
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        CONTROL     = 3'd0,
        VIDEO       = 3'd1,
        VIDEO_GB    = 3'd2,
        DATA_GB     = 3'd3,
        DATA_ISLAND = 3'd4
    } mode_e;

    // Indexed by {c1,c0}
    localparam logic [SYM_W-1:0] CTL_SYM [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    localparam logic [SYM_W-1:0] GB_A = 10'b1011001100;
    localparam logic [SYM_W-1:0] GB_B = 10'b0100110011;

`ifdef HDMI_TMDS_TERC4_EN
    localparam logic [SYM_W-1:0] TERC4_SYM [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
`endif

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder: one TMDS lane with its own running disparity.
// Stage 1 builds q_m or the non-video symbol, stage 2 balances, optional output stage.
module tmds_channel_encoder
    import hdmi_pkg::*;
#(
    parameter int OUT_REG = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [2:0]       mode_i,
    input  logic [7:0]       data_i,
    input  logic [1:0]       ctl_i,
    input  logic [3:0]       terc4_i,
    input  logic [SYM_W-1:0] gb_sym_i,
    output logic [SYM_W-1:0] sym_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [3:0]              n1_d;
    logic                    xnor_sel;
    logic                    par;
    logic [8:0]              qm_d, qm_q;
    logic [SYM_W-1:0]        alt_d, alt_q;
    logic                    vid_q;
    logic [3:0]              n1_q;
    logic signed [CNT_W-1:0] diff;
    logic                    bal;
    logic                    inv;
    logic [SYM_W-1:0]        sym_d, sym_q;
    logic signed [CNT_W-1:0] cnt_d, cnt_q;

    // The XNOR chain equals the XOR prefix with every odd bit inverted
    always_comb begin
        n1_d = popcount8(data_i);
        xnor_sel = n1_d > 4'd4 || (n1_d == 4'd4 && !data_i[0]);
        par = 1'b0;
        qm_d = '0;
        for (int i = 0; i < 8; i++) begin
            par = par ^ data_i[i];
            qm_d[i] = par ^ (xnor_sel & i[0]);
        end
        qm_d[8] = ~xnor_sel;
    end

`ifdef HDMI_TMDS_TERC4_EN
    assign alt_d = mode_i == VIDEO_GB ? gb_sym_i
                 : mode_i == DATA_ISLAND ? TERC4_SYM[terc4_i]
                 : CTL_SYM[ctl_i];
`else
    logic unused_terc4;
    assign unused_terc4 = ^terc4_i;
    assign alt_d = mode_i == VIDEO_GB ? gb_sym_i : CTL_SYM[ctl_i];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vid_q <= 1'b0;
            qm_q  <= '0;
            alt_q <= CTL_SYM[0];
        end else begin
            vid_q <= mode_i == VIDEO;
            qm_q  <= qm_d;
            alt_q <= alt_d;
        end
    end

    always_comb begin
        n1_q = popcount8(qm_q[7:0]);
        diff = {n1_q, 1'b0} - 5'd8;
        bal = cnt_q == 5'sd0 || n1_q == 4'd4;
        inv = (cnt_q > 5'sd0 && n1_q > 4'd4) || (cnt_q < 5'sd0 && n1_q < 4'd4);
        sym_d = !vid_q ? alt_q
              : bal ? {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]}
              : {inv, qm_q[8], inv ? ~qm_q[7:0] : qm_q[7:0]};
        cnt_d = !vid_q ? 5'sd0
              : bal ? (qm_q[8] ? cnt_q + diff : cnt_q - diff)
              : inv ? cnt_q + {3'b000, qm_q[8], 1'b0} - diff
              : cnt_q - {3'b000, ~qm_q[8], 1'b0} + diff;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sym_q <= CTL_SYM[0];
            cnt_q <= '0;
        end else begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [SYM_W-1:0] symo_q;
        logic [CNT_W-1:0] cnto_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                symo_q <= CTL_SYM[0];
                cnto_q <= '0;
            end else begin
                symo_q <= sym_q;
                cnto_q <= cnt_q;
            end
        end
        assign sym_o = symo_q;
        assign cnt_o = cnto_q;
    end else begin : g_noreg
        assign sym_o = sym_q;
        assign cnt_o = cnt_q;
    end

endmodule

// File: rtl/hdmi_tmds_encoder_bank.sv
// hdmi_tmds_encoder_bank: NUM_CH TMDS lanes with guard-band lane selection and fill flag.
// Define HDMI_TMDS_TERC4_EN to enable the DATA_GB / DATA_ISLAND (TERC4) paths.
module hdmi_tmds_encoder_bank
    import hdmi_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int OUT_REG = 1
) (
    input  logic                  clk_pixel,
    input  logic                  reset_n,
    input  logic [2:0]            mode,
    input  logic [NUM_CH*8-1:0]   video_data,
    input  logic [NUM_CH*2-1:0]   ctl,
    input  logic [NUM_CH*4-1:0]   terc4_data,
    output logic [NUM_CH*10-1:0]  sym_out,
    output logic                  sym_valid,
    output logic [NUM_CH*5-1:0]   disparity
);

    localparam logic [1:0] LAT = OUT_REG != 0 ? 2'd3 : 2'd2;

    logic [1:0] vcnt_d, vcnt_q;

    assign vcnt_d = vcnt_q == LAT ? vcnt_q : vcnt_q + 2'd1;
    assign sym_valid = vcnt_q == LAT;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) vcnt_q <= '0;
        else vcnt_q <= vcnt_d;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [2:0]       ch_mode;
        logic [SYM_W-1:0] gb_sym;
        // DATA_GB becomes TERC4 on lane 0 and a plain guard band elsewhere
`ifdef HDMI_TMDS_TERC4_EN
        assign ch_mode = mode == DATA_GB ? (c == 0 ? DATA_ISLAND : VIDEO_GB) : mode;
`else
        assign ch_mode = (mode == DATA_GB || mode == DATA_ISLAND) ? CONTROL : mode;
`endif
        assign gb_sym = (mode == DATA_GB || c % 3 == 1) ? GB_B : GB_A;

        tmds_channel_encoder #(.OUT_REG(OUT_REG)) u_enc (
            .clk_i    (clk_pixel),
            .rst_ni   (reset_n),
            .mode_i   (ch_mode),
            .data_i   (video_data[c*8 +: 8]),
            .ctl_i    (ctl[c*2 +: 2]),
            .terc4_i  (terc4_data[c*4 +: 4]),
            .gb_sym_i (gb_sym),
            .sym_o    (sym_out[c*10 +: 10]),
            .cnt_o    (disparity[c*5 +: 5])
        );
    end

endmodule

// File: tb/tb_hdmi_tmds_encoder_bank.sv
// tb_hdmi_tmds_encoder_bank: scoreboard bench; stimulus pushes expected symbols,
// a negedge monitor pops and compares whenever sym_valid is high.
module tb_hdmi_tmds_encoder_bank;

    localparam int NCH  = 3;
    localparam int OREG = 1;
    localparam int LAT  = OREG != 0 ? 3 : 2;
    localparam logic [2:0] M_CTL = 3'd0, M_VID = 3'd1, M_VGB = 3'd2, M_DGB = 3'd3, M_DI = 3'd4;
    localparam logic [9:0] GB_A = 10'b1011001100, GB_B = 10'b0100110011;
    localparam logic [9:0] CTL0 = 10'b1101010100;
`ifdef HDMI_TMDS_TERC4_EN
    localparam logic [9:0] DI_A = 10'b0110011100, DGB_5 = 10'b0100011110;
`else
    localparam logic [9:0] DI_A = 10'b0101010100, DGB_5 = 10'b0010101011;
`endif

    typedef struct {
        logic [NCH*10-1:0] sym;
        logic [NCH*5-1:0]  disp;
        bit                hand;
        logic [9:0]        hsym;
        logic [4:0]        hdisp;
        int                id;
    } exp_t;

    logic             clk_pixel = 1'b0;
    logic             reset_n = 1'b1;
    logic [2:0]       mode = 3'd0;
    logic [NCH*8-1:0] video_data = '0;
    logic [NCH*2-1:0] ctl = '0;
    logic [NCH*4-1:0] terc4_data = '0;
    logic [NCH*10-1:0] sym_out;
    logic             sym_valid;
    logic [NCH*5-1:0] disparity;

    exp_t q[$];
    exp_t cur;
    int   mcnt [NCH];
    int   n_chk = 0;
    int   n_pass = 0;
    int   vec_id = 0;

    always #5 clk_pixel = ~clk_pixel;

    hdmi_tmds_encoder_bank #(.NUM_CH(NCH), .OUT_REG(OREG)) dut (
        .clk_pixel  (clk_pixel),
        .reset_n    (reset_n),
        .mode       (mode),
        .video_data (video_data),
        .ctl        (ctl),
        .terc4_data (terc4_data),
        .sym_out    (sym_out),
        .sym_valid  (sym_valid),
        .disparity  (disparity)
    );

    function automatic void check(input string nm, input int id, input int lane,
                                  input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s vec=%0d lane=%0d got=%0b expected=%0b", nm, id, lane, act, req);
    endfunction

    function automatic logic [9:0] ctl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] t4_sym(input logic [3:0] n);
        case (n)
            4'h0: return 10'b1010011100;  4'h1: return 10'b1001100011;
            4'h2: return 10'b1011100100;  4'h3: return 10'b1011100010;
            4'h4: return 10'b0101110001;  4'h5: return 10'b0100011110;
            4'h6: return 10'b0110001110;  4'h7: return 10'b0100111100;
            4'h8: return 10'b1011001100;  4'h9: return 10'b0100111001;
            4'hA: return 10'b0110011100;  4'hB: return 10'b1011000110;
            4'hC: return 10'b1010001110;  4'hD: return 10'b1001110001;
            4'hE: return 10'b0101100011;  default: return 10'b1011000011;
        endcase
    endfunction

    // Textbook DVI 1.0 encoder written with chained q_m and integer counts
    function automatic void vid_model(input logic [7:0] d, input int cin,
                                      output logic [9:0] s, output int cout);
        int n1, a, b;
        bit xn;
        logic [8:0] qm;
        n1 = $countones(d);
        xn = n1 > 4 || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        a = $countones(qm[7:0]);
        b = 8 - a;
        if (cin == 0 || a == b) begin
            s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cout = cin + (qm[8] ? a - b : b - a);
        end else if ((cin > 0 && a > b) || (cin < 0 && b > a)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            cout = cin + 2 * int'(qm[8]) + b - a;
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            cout = cin - 2 * int'(!qm[8]) + a - b;
        end
    endfunction

    function automatic void push_exp(input logic [2:0] m, input logic [NCH*8-1:0] vd,
                                     input logic [NCH*2-1:0] c, input logic [NCH*4-1:0] t,
                                     input bit hand, input logic [9:0] hs, input int hd);
        exp_t e;
        logic [9:0] s;
        int em, nc;
        for (int ch = 0; ch < NCH; ch++) begin
            em = m > 3'd4 ? 0 : int'(m);
`ifndef HDMI_TMDS_TERC4_EN
            if (em == 3 || em == 4) em = 0;
`endif
            if (em == 1) begin
                vid_model(vd[ch*8 +: 8], mcnt[ch], s, nc);
                mcnt[ch] = nc;
            end else begin
                mcnt[ch] = 0;
                s = em == 2 ? (ch % 3 == 1 ? GB_B : GB_A)
                  : em == 3 ? (ch == 0 ? t4_sym(t[3:0]) : GB_B)
                  : em == 4 ? t4_sym(t[ch*4 +: 4])
                  : ctl_sym(c[ch*2 +: 2]);
            end
            e.sym[ch*10 +: 10] = s;
            e.disp[ch*5 +: 5] = 5'(mcnt[ch]);
        end
        e.hand = hand;
        e.hsym = hs;
        e.hdisp = 5'(hd);
        e.id = vec_id++;
        q.push_back(e);
    endfunction

    task automatic drv(input logic [2:0] m, input logic [NCH*8-1:0] vd, input logic [NCH*2-1:0] c,
                       input logic [NCH*4-1:0] t, input bit hand, input logic [9:0] hs, input int hd);
        mode = m;
        video_data = vd;
        ctl = c;
        terc4_data = t;
        push_exp(m, vd, c, t, hand, hs, hd);
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic check_reset(input string nm);
        for (int ch = 0; ch < NCH; ch++) begin
            check({nm, "_sym"}, -1, ch, 32'(sym_out[ch*10 +: 10]), 32'(CTL0));
            check({nm, "_disp"}, -1, ch, 32'(disparity[ch*5 +: 5]), 32'd0);
        end
        check({nm, "_valid"}, -1, 0, 32'(sym_valid), 32'd0);
    endtask

    task automatic probe_latency();
        int k = 0;
        while (!sym_valid && k < 10) begin
            @(posedge clk_pixel);
            #1;
            k++;
        end
        check("valid_latency", -1, 0, k, LAT);
    endtask

    always @(negedge clk_pixel) begin
        if (reset_n && sym_valid && q.size() > 0) begin
            cur = q.pop_front();
            for (int ch = 0; ch < NCH; ch++) begin
                check("sym", cur.id, ch, 32'(sym_out[ch*10 +: 10]), 32'(cur.sym[ch*10 +: 10]));
                check("disp", cur.id, ch, 32'(disparity[ch*5 +: 5]), 32'(cur.disp[ch*5 +: 5]));
            end
            if (cur.hand) begin
                check("hand_sym", cur.id, 0, 32'(sym_out[9:0]), 32'(cur.hsym));
                check("hand_disp", cur.id, 0, 32'(disparity[4:0]), 32'(cur.hdisp));
            end
        end
    end

    initial begin
        int k;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk_pixel);
        #1 check_reset("por");
        reset_n = 1'b1;
        fork probe_latency(); join_none
        drv(M_VID, 24'h000000, 6'b000000, 12'h000, 1, 10'b0100000000, -8);
        drv(M_VID, 24'h000000, 6'b000000, 12'h000, 1, 10'b1111111111, 2);
        drv(M_VID, 24'h000000, 6'b000000, 12'h000, 1, 10'b0100000000, -6);
        drv(M_VID, 24'h55ff10, 6'b000000, 12'h000, 0, 10'b0, 0);
        drv(M_VID, 24'haa0f38, 6'b000000, 12'h000, 0, 10'b0, 0);
        drv(M_CTL, 24'h000000, 6'b111001, 12'h000, 1, 10'b0010101011, 0);
        drv(M_VID, 24'h000000, 6'b000000, 12'h000, 1, 10'b0100000000, -8);
        drv(M_CTL, 24'h000000, 6'b000000, 12'h000, 1, 10'b1101010100, 0);
        drv(M_VID, 24'h7e33ff, 6'b000000, 12'h000, 1, 10'b1000000000, -8);
        drv(M_CTL, 24'h000000, 6'b000110, 12'h000, 1, 10'b0101010100, 0);
        drv(M_CTL, 24'h000000, 6'b100111, 12'h000, 1, 10'b1010101011, 0);
        drv(3'd7,  24'h123456, 6'b000011, 12'h000, 1, 10'b1010101011, 0);
        drv(M_VGB, 24'h000000, 6'b000000, 12'h000, 1, 10'b1011001100, 0);
        drv(M_DI,  24'h000000, 6'b000010, 12'haaa, 1, DI_A, 0);
        drv(M_DGB, 24'h000000, 6'b000001, 12'h3c5, 1, DGB_5, 0);
        drv(M_VID, 24'hc3a5f0, 6'b000000, 12'h000, 0, 10'b0, 0);
        drv(M_VID, 24'h01fe80, 6'b000000, 12'h000, 0, 10'b0, 0);
        reset_n = 1'b0;
        #1 check_reset("mid");
        q.delete();
        foreach (mcnt[i]) mcnt[i] = 0;
        @(posedge clk_pixel);
        #1 reset_n = 1'b1;
        fork probe_latency(); join_none
        drv(M_VID, 24'h000000, 6'b000000, 12'h000, 1, 10'b0100000000, -8);
        for (int i = 0; i < 18; i++)
            drv(i % 3 == 0 ? M_VID : i % 3 == 1 ? M_CTL : M_DGB,
                24'($urandom), 6'($urandom), 12'($urandom), 0, 10'b0, 0);
        for (int i = 0; i < 16; i++)
            drv(M_VID, 24'($urandom), 6'b000000, 12'h000, 0, 10'b0, 0);
        mode = M_CTL;
        ctl = '0;
        k = 0;
        while (q.size() > 0 && k < 50) begin
            @(posedge clk_pixel);
            k++;
        end
        #1 check("drain", -1, 0, q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hdmi_tmds_encoder_bank.md
HDMI_TMDS_ENCODER_BANK -- requirements
Module: hdmi_tmds_encoder_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of TMDS data channels (1..8); channel 0 carries sync.
REQ-002 SHALL have parameter OUT_REG, default 1; 1 adds an output register stage.
REQ-003 SHALL have port clk_pixel  input  1  pixel clock; the only clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port mode  input  3  hdmi_pkg::mode_e, one value per cycle: CONTROL, VIDEO, VIDEO_GB, DATA_GB, DATA_ISLAND.
REQ-006 SHALL have port video_data  input  NUM_CH*8  8-bit pixel component per channel; channel 0 is bits [7:0].
REQ-007 SHALL have port ctl  input  NUM_CH*2  {c1,c0} per channel; channel 0 is {vsync,hsync}.
REQ-008 SHALL have port terc4_data  input  NUM_CH*4  TERC4 nibble per channel.
REQ-009 SHALL have port sym_out  output  NUM_CH*10  10-bit symbol per channel; bit 0 is transmitted first.
REQ-010 SHALL have port sym_valid  output  1  pipeline-filled flag.
REQ-011 SHALL have port disparity  output  NUM_CH*5  signed running disparity per channel, for debug.

Function
REQ-012 SHALL accept one input set every cycle with no stall; sym_out SHALL reflect the inputs sampled at cycle t at t+2 (OUT_REG=0) or t+3 (OUT_REG=1).
REQ-013 SHALL pipeline mode alongside the data, so mode changes take effect per cycle with no bubbles or mixed symbols.
REQ-014 VIDEO stage 1 SHALL compute q_m:
- N1 = popcount(d).
- If N1>4, or N1==4 and d[0]==0: XNOR chain, q_m[8]=0.
- Otherwise: XOR chain, q_m[8]=1.
REQ-015 VIDEO stage 2 SHALL apply DVI 1.0 balancing, with cnt = ones minus zeros:
- If cnt==0 or N1(q_m[7:0])==4: q[9]=~q_m[8], q[8]=q_m[8], q[7:0]=q_m[8]?q_m:~q_m; cnt += q_m[8] ? (N1-N0) : (N0-N1).
- Else, if (cnt>0 and N1>N0) or (cnt<0 and N0>N1): invert q_m[7:0], q[9]=1, q[8]=q_m[8]; cnt += 2*q_m[8] + (N0-N1).
- Else: no inversion, q[9]=0, q[8]=q_m[8]; cnt += -2*(~q_m[8]) + (N1-N0).
REQ-016 cnt SHALL be 5-bit signed and SHALL never overflow; legal range is -10..+10.
REQ-017 CONTROL SHALL emit 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011 (ctl value -> symbol, bit9..bit0).
REQ-018 VIDEO_GB SHALL emit:
- channels with index mod 3 == 1: 0100110011.
- all others: 1011001100.
REQ-019 DATA_GB SHALL emit:
- channel 0: TERC4(terc4_data ch0).
- other channels: 0100110011.
REQ-020 DATA_ISLAND SHALL emit TERC4(terc4_data) on every channel.
REQ-021 TERC4 table 0..F SHALL be: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
REQ-022 Every non-VIDEO mode SHALL clear cnt to 0 in the stage where its symbol is produced.
REQ-023 Undefined mode encodings SHALL be treated as CONTROL.
REQ-024 disparity SHALL show the cnt value after the symbol currently on sym_out.

Reset
REQ-025 While reset_n is low, all pipeline stages SHALL asynchronously load CONTROL with ctl=00: every sym_out lane 1101010100, cnt 0, sym_valid 0.
REQ-026 After release, sym_valid SHALL rise exactly at pipeline latency (2 or 3 cycles) and stay high until the next reset.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight symbols.

Configuration
REQ-028 Macro HDMI_TMDS_TERC4_EN SHALL compile in the TERC4 table and the DATA_GB/DATA_ISLAND paths.
REQ-029 With HDMI_TMDS_TERC4_EN undefined, DATA_GB and DATA_ISLAND SHALL be treated as CONTROL using ctl; the terc4_data port SHALL remain and be ignored.

Structure
REQ-030 hdmi_pkg SHALL hold mode_e, the four control symbols, both guard-band symbols, the TERC4 table and the symbol width constant.
REQ-031 SHALL instantiate NUM_CH copies of sub-module tmds_channel_encoder (one channel, its own cnt); the bank adds the guard-band channel selection and the sym_valid counter.

Verification
REQ-032 Reset: reset_n=0 -> all lanes 1101010100, sym_valid=0; release -> sym_valid=1 on cycle 2 (OUT_REG=0) or cycle 3 (OUT_REG=1).
REQ-033 VIDEO 0x00 repeated from cnt=0 -> lane sequence 0100000000, 1111111111, 0100000000...; disparity -8, +2, -6.
REQ-034 VIDEO burst then one CONTROL cycle with ctl ch0=01 -> that slot 0010101011 and disparity 0; the next VIDEO 0x00 -> 0100000000.
REQ-035 VIDEO_GB with NUM_CH=3 -> lanes 1011001100, 0100110011, 1011001100.
REQ-036 DATA_ISLAND with terc4_data=4'hA on all lanes -> 0110011100 when the macro is defined; control symbol from ctl when undefined.
REQ-037 Alternating mode each cycle (VIDEO/CONTROL/DATA_GB), checked against a reference model -> zero mismatches, latency constant, no bubbles.
